// File: rtl/maxnet_pkg.sv
// Shared constants, FSM state encoding and FP32 helpers for the Maxnet controller.
package maxnet_pkg;

   localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
   localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;
   localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SUM,
      UPD_T,
      UPD_N,
      CHECK,
      DONE
   } state_t;

   // Clamp to +0: any negative value (including -0) and any zero become 32'h0.
   function automatic logic [31:0] relu_fp32(input logic [31:0] x);
      logic [31:0] r;
      r = x;
      if (x[31] || (x[30:0] == 31'h0)) r = FP_ZERO;
      return r;
   endfunction

endpackage

// File: rtl/maxnet_ctrl_fma_issue.sv
// Single-outstanding issue slot towards the shared FP fused multiply-add unit.
// Operands are latched on op_req and held with fma_valid until accepted; the
// returned result is registered and presented as a one-cycle res_valid strobe.
module maxnet_fma_issue
   import maxnet_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        op_req,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [31:0] op_c,
   output logic [31:0] fma_a,
   output logic [31:0] fma_b,
   output logic [31:0] fma_c,
   output logic        fma_valid,
   input  logic        fma_ready,
   input  logic [31:0] fma_res,
   input  logic        fma_res_valid,
   output logic [31:0] res,
   output logic        res_valid
);

   logic waiting;

   // Issue / wait-for-result slot; results arriving while not waiting are dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fma_a     <= FP_ZERO;
         fma_b     <= FP_ZERO;
         fma_c     <= FP_ZERO;
         fma_valid <= 1'b0;
         waiting   <= 1'b0;
         res       <= FP_ZERO;
         res_valid <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         if (op_req && !fma_valid && !waiting) begin
            fma_a     <= op_a;
            fma_b     <= op_b;
            fma_c     <= op_c;
            fma_valid <= 1'b1;
         end else if (fma_valid && fma_ready) begin
            fma_valid <= 1'b0;
            waiting   <= 1'b1;
         end else if (waiting && fma_res_valid) begin
            res       <= fma_res;
            res_valid <= 1'b1;
            waiting   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/maxnet_ctrl.sv
// Iteration controller for a 4-input winner-take-all Maxnet on FP32 values.
// All arithmetic is serialised through one external FMA via maxnet_fma_issue.
module maxnet_ctrl
   import maxnet_pkg::*;
#(
   parameter int MAX_ITER = 64,
   parameter int ITER_W   = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       num1,
   input  logic [31:0]       num2,
   input  logic [31:0]       num3,
   input  logic [31:0]       num4,
   input  logic [31:0]       epsilon,
   output logic [31:0]       fma_a,
   output logic [31:0]       fma_b,
   output logic [31:0]       fma_c,
   output logic              fma_valid,
   input  logic              fma_ready,
   input  logic [31:0]       fma_res,
   input  logic              fma_res_valid,
   output logic [31:0]       max,
   output logic [1:0]        max_idx,
   output logic [ITER_W-1:0] iter_count,
   output logic              done,
   output logic              timeout
);

   state_t            state, state_next;
   logic              start_q;
   logic [31:0]       orig [4];
   logic [31:0]       act  [4];
   logic [31:0]       neg_eps, sum_r, t_r;
   logic [1:0]        idx, step;
   logic              pend, shortcut;
   logic              start_edge;
   logic [3:0]        nz, load_nz;
   logic [2:0]        nz_cnt, load_cnt, low_nz, next_nz;
   logic [ITER_W-1:0] chk_iter;
   logic              chk_timeout;
   logic [1:0]        win;
   logic              op_req;
   logic [31:0]       op_a, op_b, op_c;
   logic [31:0]       res;
   logic              res_valid;

   function automatic logic [2:0] pop4(input logic [3:0] m);
      return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
   endfunction

   // Lowest set index at or above 'from'; 3'b100 when there is none.
   function automatic logic [2:0] first_nz(input logic [3:0] m, input logic [2:0] from);
      logic [2:0] r;
      r = 3'b100;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (3'(i) >= from)) r = {1'b0, 2'(i)};
      end
      return r;
   endfunction

   // Nonzero masks of the live activations and of the freshly loaded inputs.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         nz[i]      = (act[i] != FP_ZERO);
         load_nz[i] = (relu_fp32(orig[i]) != FP_ZERO);
      end
   end

   assign start_edge  = start && !start_q;
   assign nz_cnt      = pop4(nz);
   assign load_cnt    = pop4(load_nz);
   assign low_nz      = first_nz(nz, 3'd0);
   assign next_nz     = first_nz(nz, {1'b0, idx} + 3'd1);
   assign win         = low_nz[2] ? 2'd0 : low_nz[1:0];
   assign chk_iter    = shortcut ? iter_count : iter_count + ITER_W'(1);
   assign chk_timeout = (nz_cnt >= 3'd2) && (chk_iter == ITER_W'(MAX_ITER));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state logic and FMA operand selection for the current step.
   always_comb begin
      state_next = state;
      op_req     = 1'b0;
      op_a       = FP_ZERO;
      op_b       = FP_ZERO;
      op_c       = FP_ZERO;
      case (state)
         IDLE: begin
            if (start_edge) state_next = LOAD;
         end
         LOAD: begin
            state_next = (load_cnt < 3'd2) ? CHECK : SUM;
         end
         SUM: begin
            op_req = !pend;
            op_b   = FP_ONE;
            case (step)
               2'd0: begin
                  op_a = act[0];
                  op_c = act[1];
               end
               2'd1: begin
                  op_a = act[2];
                  op_c = sum_r;
               end
               default: begin
                  op_a = act[3];
                  op_c = sum_r;
               end
            endcase
            if (res_valid && (step == 2'd2)) state_next = UPD_T;
         end
         UPD_T: begin
            op_req = !pend;
            op_a   = act[idx];
            op_b   = FP_NEG_ONE;
            op_c   = sum_r;
            if (res_valid) state_next = UPD_N;
         end
         UPD_N: begin
            op_req = !pend;
            op_a   = neg_eps;
            op_b   = t_r;
            op_c   = act[idx];
            if (res_valid) state_next = next_nz[2] ? CHECK : UPD_T;
         end
         CHECK: begin
            if (shortcut || (nz_cnt < 3'd2) || chk_timeout) state_next = DONE;
            else                                             state_next = SUM;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Activation, accumulator and result registers advanced by the FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_q    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            orig[i] <= FP_ZERO;
            act[i]  <= FP_ZERO;
         end
         neg_eps    <= FP_ZERO;
         sum_r      <= FP_ZERO;
         t_r        <= FP_ZERO;
         idx        <= 2'd0;
         step       <= 2'd0;
         pend       <= 1'b0;
         shortcut   <= 1'b0;
         max        <= FP_ZERO;
         max_idx    <= 2'd0;
         iter_count <= '0;
         done       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         start_q <= start;
         done    <= 1'b0;
         if (op_req)         pend <= 1'b1;
         else if (res_valid) pend <= 1'b0;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  orig[0]    <= num1;
                  orig[1]    <= num2;
                  orig[2]    <= num3;
                  orig[3]    <= num4;
                  neg_eps    <= {~epsilon[31], epsilon[30:0]};
                  iter_count <= '0;
                  timeout    <= 1'b0;
               end
            end
            LOAD: begin
               for (int i = 0; i < 4; i++) act[i] <= relu_fp32(orig[i]);
               shortcut <= (load_cnt < 3'd2);
               step     <= 2'd0;
            end
            SUM: begin
               if (res_valid) begin
                  sum_r <= res;
                  step  <= step + 2'd1;
                  if (step == 2'd2) idx <= low_nz[1:0];
               end
            end
            UPD_T: begin
               if (res_valid) t_r <= res;
            end
            UPD_N: begin
               if (res_valid) begin
                  act[idx] <= relu_fp32(res);
                  if (!next_nz[2]) idx <= next_nz[1:0];
               end
            end
            CHECK: begin
               iter_count <= chk_iter;
               step       <= 2'd0;
               shortcut   <= 1'b0;
               if (state_next == DONE) begin
                  done    <= 1'b1;
                  max     <= orig[win];
                  max_idx <= win;
                  timeout <= chk_timeout;
               end
            end
            default: ;
         endcase
      end
   end

   maxnet_fma_issue u_issue (
      .clk           (clk),
      .rst           (rst),
      .op_req        (op_req),
      .op_a          (op_a),
      .op_b          (op_b),
      .op_c          (op_c),
      .fma_a         (fma_a),
      .fma_b         (fma_b),
      .fma_c         (fma_c),
      .fma_valid     (fma_valid),
      .fma_ready     (fma_ready),
      .fma_res       (fma_res),
      .fma_res_valid (fma_res_valid),
      .res           (res),
      .res_valid     (res_valid)
   );

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Scoreboard bench for maxnet_ctrl: a main instance plus a MAX_ITER=4 instance for the tie case.
module tb_maxnet_ctrl;

   localparam logic [31:0] ONE = 32'h3F80_0000;

   typedef struct {
      logic [31:0] mx;
      logic [1:0]  idx;
      int          iter;
      logic        to;
      int          ops;
      int          it1;
      int          it2;
      int          lat;
   } exp_t;

   logic        clk, rst, start, start4;
   logic [31:0] num1, num2, num3, num4, epsilon;
   logic [31:0] fma_a, fma_b, fma_c, fma_res, max;
   logic        fma_valid, fma_ready, fma_res_valid, done, timeout;
   logic [1:0]  max_idx;
   logic [6:0]  iter_count;
   logic [31:0] fma4_a, fma4_b, fma4_c, fma4_res, max4;
   logic        fma4_valid, fma4_ready, fma4_res_valid, done4, timeout4;
   logic [1:0]  max_idx4;
   logic [6:0]  iter_count4;

   int   n_tests = 0, n_fail = 0;
   exp_t sbq[$], sbq4[$];
   exp_t mon_e, mon4_e;
   int   done_cnt = 0, done4_cnt = 0;
   int   tot_ops = 0, cur_ops = 0, ones_cnt = 0, valid_cycles = 0;
   int   iter_ops[$];
   int   cyc = 0, start_cyc = 0;
   logic start_d = 1'b0;
   bit   bp_mode = 0;
   int   lat_fix = 1;
   bit   m_busy = 0, p4 = 0;
   int   m_cnt = 0;
   logic [31:0] m_res, r4;
   bit   stall_q = 0;
   logic [31:0] sa, sb, sc;
   int   stab_err = 0, stab_checks = 0;

   maxnet_ctrl #(.MAX_ITER(64), .ITER_W(7)) dut (
      .clk(clk), .rst(rst), .start(start),
      .num1(num1), .num2(num2), .num3(num3), .num4(num4), .epsilon(epsilon),
      .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_valid(fma_valid),
      .fma_ready(fma_ready), .fma_res(fma_res), .fma_res_valid(fma_res_valid),
      .max(max), .max_idx(max_idx), .iter_count(iter_count), .done(done), .timeout(timeout)
   );

   maxnet_ctrl #(.MAX_ITER(4), .ITER_W(7)) dut4 (
      .clk(clk), .rst(rst), .start(start4),
      .num1(num1), .num2(num2), .num3(num3), .num4(num4), .epsilon(epsilon),
      .fma_a(fma4_a), .fma_b(fma4_b), .fma_c(fma4_c), .fma_valid(fma4_valid),
      .fma_ready(fma4_ready), .fma_res(fma4_res), .fma_res_valid(fma4_res_valid),
      .max(max4), .max_idx(max_idx4), .iter_count(iter_count4), .done(done4), .timeout(timeout4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FP32 <-> real conversion for the reference FMA (denormals flushed to zero).
   function automatic real f2r(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'd0) return 0.0;
      d = {x[31], ({3'b000, x[30:23]} + 11'd896), x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [24:0] m;
      logic [28:0] rest;
      int          e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      e    = int'(d[62:52]) - 896;
      m    = {2'b01, d[51:29]};
      rest = d[28:0];
      if ((rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e <= 0)   return {d[63], 31'd0};
      if (e >= 255) return {d[63], 8'hFF, 23'd0};
      return {d[63], 8'(e), m[22:0]};
   endfunction

   function automatic logic [31:0] fma32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return r2f(f2r(a) * f2r(b) + f2r(c));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Cycle counter and start-edge timestamp.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (start && !start_d) start_cyc = cyc;
         start_d = start;
         if (fma_valid) valid_cycles++;
      end
   end

   // FMA model for the main instance: optional backpressure and variable latency.
   initial begin
      fma_ready = 1'b1;
      fma_res_valid = 1'b0;
      fma_res = 32'h0;
      forever begin
         @(posedge clk);
         if (fma_valid && fma_ready) begin
            m_busy = 1;
            m_res  = fma32(fma_a, fma_b, fma_c);
            m_cnt  = bp_mode ? int'($urandom_range(1, 6)) : lat_fix;
            if (fma_b == ONE) begin
               if ((ones_cnt % 3 == 0) && (ones_cnt > 0)) begin
                  iter_ops.push_back(cur_ops);
                  cur_ops = 0;
               end
               ones_cnt++;
            end
            cur_ops++;
            tot_ops++;
         end
         #1;
         fma_res_valid = 1'b0;
         if (m_busy) begin
            m_cnt--;
            if (m_cnt <= 0) begin
               fma_res = m_res;
               fma_res_valid = 1'b1;
               m_busy = 0;
            end
         end
         fma_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // FMA model for the MAX_ITER=4 instance: latency 1, always ready.
   initial begin
      fma4_ready = 1'b1;
      fma4_res_valid = 1'b0;
      fma4_res = 32'h0;
      forever begin
         @(posedge clk);
         if (fma4_valid && fma4_ready) begin
            p4 = 1;
            r4 = fma32(fma4_a, fma4_b, fma4_c);
         end
         #1;
         fma4_res_valid = 1'b0;
         if (p4) begin
            fma4_res = r4;
            fma4_res_valid = 1'b1;
            p4 = 0;
         end
      end
   end

   // Operands must stay frozen while a request is stalled.
   initial begin
      forever begin
         @(posedge clk);
         if (stall_q && rst) begin
            stab_checks++;
            if (!fma_valid || (fma_a !== sa) || (fma_b !== sb) || (fma_c !== sc)) stab_err++;
         end
         stall_q = rst && fma_valid && !fma_ready;
         sa = fma_a;
         sb = fma_b;
         sc = fma_c;
      end
   end

   // Monitor: pop the expected result for every done pulse of the main instance.
   initial begin
      forever begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1, expected no run in flight");
            end else begin
               mon_e = sbq.pop_front();
               chk("max", max, mon_e.mx);
               chk("max_idx", 32'(max_idx), 32'(mon_e.idx));
               chk("iter_count", 32'(iter_count), mon_e.iter);
               chk("timeout", 32'(timeout), 32'(mon_e.to));
               if (mon_e.ops >= 0) chk("total_ops", tot_ops, mon_e.ops);
               if (mon_e.it1 >= 0) chk("iter1_ops", (iter_ops.size() > 0) ? iter_ops[0] : -1, mon_e.it1);
               if (mon_e.it2 >= 0) chk("iter2_ops", (iter_ops.size() > 1) ? iter_ops[1] : -1, mon_e.it2);
               if (mon_e.lat >= 0) chk("done_latency", cyc - start_cyc, mon_e.lat);
               if (!bp_mode && (mon_e.ops >= 0)) chk("valid_cycles", valid_cycles, mon_e.ops);
            end
         end
      end
   end

   // Monitor for the MAX_ITER=4 instance.
   initial begin
      forever begin
         @(negedge clk);
         if (done4) begin
            done4_cnt++;
            if (sbq4.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done4: got done=1, expected no run in flight");
            end else begin
               mon4_e = sbq4.pop_front();
               chk("tie_max", max4, mon4_e.mx);
               chk("tie_max_idx", 32'(max_idx4), 32'(mon4_e.idx));
               chk("tie_iter_count", 32'(iter_count4), mon4_e.iter);
               chk("tie_timeout", 32'(timeout4), 32'(mon4_e.to));
            end
         end
      end
   end

   task automatic launch(input logic [31:0] n1, input logic [31:0] n2, input logic [31:0] n3,
                         input logic [31:0] n4, input logic [31:0] e, input exp_t ex,
                         input bit do_push, input bit hold);
      num1 = n1; num2 = n2; num3 = n3; num4 = n4; epsilon = e;
      tot_ops = 0; cur_ops = 0; ones_cnt = 0; valid_cycles = 0;
      iter_ops.delete();
      if (do_push) sbq.push_back(ex);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = hold;
   endtask

   task automatic wait_done(input int budget, input string nm);
      int d0;
      bit got;
      d0 = done_cnt;
      got = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(posedge clk);
         if (done_cnt > d0) got = 1;
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s: got no done within %0d cycles, expected done", nm, budget);
      end
      #1;
   endtask

   localparam logic [31:0] N1 = 32'h3ECC_CCCD, N2 = 32'h3FCC_CCCD, N3 = 32'h3FD9_999A,
                           N4 = 32'h3FA6_6666, EPS = 32'h3E99_999A;

   initial begin
      exp_t nom;
      exp_t tie;
      int   d0;
      bit   hit;
      nom = '{32'h3FD9_999A, 2'd2, 5, 1'b0, 41, 11, 9, -1};
      tie = '{32'h3F80_0000, 2'd0, 4, 1'b1, -1, -1, -1, -1};
      rst = 1'b1; start = 1'b0; start4 = 1'b0;
      num1 = 0; num2 = 0; num3 = 0; num4 = 0; epsilon = 0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_max", max, 32'h0);
      chk("rst_max_idx", 32'(max_idx), 32'h0);
      chk("rst_iter_count", 32'(iter_count), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      chk("rst_fma_valid", 32'(fma_valid), 32'h0);
      chk("rst_fma_a", fma_a, 32'h0);
      chk("rst_fma_b", fma_b, 32'h0);
      chk("rst_fma_c", fma_c, 32'h0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      launch(N1, N2, N3, N4, EPS, nom, 1, 0);
      wait_done(3000, "nominal_done");
      repeat (2) @(posedge clk);
      #1;

      bp_mode = 1; stab_err = 0; stab_checks = 0;
      launch(N1, N2, N3, N4, EPS, nom, 1, 0);
      wait_done(5000, "backpressure_done");
      bp_mode = 0;
      chk("stall_operands_stable", stab_err, 0);
      chk("stalls_exercised", 32'(stab_checks > 0), 32'h1);
      repeat (3) @(posedge clk);
      #1;

      launch(32'h4000_0000, 32'hBF80_0000, 32'h8000_0000, 32'h0, EPS,
             '{32'h4000_0000, 2'd0, 0, 1'b0, 0, -1, -1, 2}, 1, 0);
      wait_done(50, "single_done");
      launch(32'hBF80_0000, 32'hC000_0000, 32'h8000_0000, 32'h0, EPS,
             '{32'hBF80_0000, 2'd0, 0, 1'b0, 0, -1, -1, 2}, 1, 0);
      wait_done(50, "allzero_done");
      launch(32'h0, 32'h0, 32'h0, 32'h4040_0000, EPS,
             '{32'h4040_0000, 2'd3, 0, 1'b0, 0, -1, -1, 2}, 1, 0);
      wait_done(50, "single_idx3_done");

      num1 = ONE; num2 = ONE; num3 = 0; num4 = 0; epsilon = EPS;
      sbq4.push_back(tie);
      d0 = done4_cnt;
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      for (int i = 0; i < 2000 && done4_cnt == d0; i++) @(posedge clk);
      chk("tie_done_seen", 32'(done4_cnt > d0), 32'h1);
      #1;

      lat_fix = 4;
      launch(N1, N2, N3, N4, EPS, nom, 0, 0);
      hit = 0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(posedge clk);
         #2;
         if ((tot_ops >= 15) && m_busy) hit = 1;
      end
      chk("rst_mid_op_outstanding", 32'(hit), 32'h1);
      d0 = done_cnt;
      rst = 1'b0;
      #1;
      chk("midrst_max", max, 32'h0);
      chk("midrst_max_idx", 32'(max_idx), 32'h0);
      chk("midrst_iter_count", 32'(iter_count), 32'h0);
      chk("midrst_fma_valid", 32'(fma_valid), 32'h0);
      chk("midrst_fma_a", fma_a, 32'h0);
      chk("midrst_timeout", 32'(timeout), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      valid_cycles = 0;
      for (int i = 0; i < 20 && m_busy; i++) @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      chk("late_result_no_reissue", valid_cycles, 0);
      chk("late_result_no_done", done_cnt, d0);
      lat_fix = 1;
      launch(N1, N2, N3, N4, EPS, nom, 1, 0);
      wait_done(3000, "rerun_done");
      repeat (2) @(posedge clk);
      #1;

      launch(N1, N2, N3, N4, EPS, nom, 1, 1);
      wait_done(3000, "held_done");
      d0 = done_cnt;
      valid_cycles = 0;
      repeat (40) @(posedge clk);
      #1;
      chk("held_no_retrigger_done", done_cnt, d0);
      chk("held_no_retrigger_ops", valid_cycles, 0);
      start = 1'b0;
      @(posedge clk);
      #1;
      launch(N1, N2, N3, N4, EPS, nom, 1, 0);
      wait_done(3000, "retrigger_done");
      repeat (3) @(posedge clk);
      #1;

      chk("scoreboard_empty", sbq.size(), 0);
      chk("scoreboard4_empty", sbq4.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
